// File: rtl/seg7_mux_decoder.sv
// Dual-digit multiplexed 7-segment receiver: resynchronises the segment/select lines, waits for a
// stable pattern in each select phase, decodes it to BCD and reassembles a 0..99 value.
// Optional build macro SEG7_DECODE_CHANGE_ONLY_EN: o_valid only fires when the decoded value changes.
//
// state   | meaning
// IDLE    | after reset, waiting for the first select edge
// SETTLE  | counting consecutive cycles with an unchanged segment pattern
// CAPTURE | one cycle: decode the settled pattern into the tens or ones digit
// WAIT    | digit for this select phase already taken, waiting for the next edge
module seg7_mux_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_seg,
  input  logic       i_sel,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [6:0] o_value,
  output logic       o_valid,
  output logic       o_err
);

  localparam logic [7:0] SETTLE_TC = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, WAIT} state_t;

  state_t     state;
  logic [6:0] seg_s1, seg_s2, seg_prev;
  logic       sel_s1, sel_s2, sel_prev;
  logic [7:0] cnt;
  logic       phase;
  logic       tens_seen;
  logic       had_valid;

  logic [6:0] seg_lit;
  logic       sel_edge;
  logic [3:0] digit;
  logic       digit_ok;
  logic       frame_ok;
  logic [6:0] frame_value;
  logic       report;

  assign seg_lit  = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
  assign sel_edge = sel_s2 ^ sel_prev;

  // seg_prev holds the settled pattern during CAPTURE, even if the line moves that cycle
  always_comb begin
    digit = 4'hF;
    case (seg_prev)
      7'b0111111: digit = 4'd0;
      7'b0000110: digit = 4'd1;
      7'b1011011: digit = 4'd2;
      7'b1001111: digit = 4'd3;
      7'b1100110: digit = 4'd4;
      7'b1101101: digit = 4'd5;
      7'b1111101: digit = 4'd6;
      7'b0000111: digit = 4'd7;
      7'b1111111: digit = 4'd8;
      7'b1100111: digit = 4'd9;
      default:    digit = 4'hF;
    endcase
  end

  assign digit_ok    = (digit != 4'hF);
  assign frame_ok    = digit_ok && !o_err;
  assign frame_value = ({3'b000, o_tens} << 3) + ({3'b000, o_tens} << 1) + {3'b000, digit};

`ifdef SEG7_DECODE_CHANGE_ONLY_EN
  assign report = !had_valid || (frame_value != o_value);
`else
  assign report = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      seg_s1    <= '0;
      seg_s2    <= '0;
      seg_prev  <= '0;
      sel_s1    <= 1'b0;
      sel_s2    <= 1'b0;
      sel_prev  <= 1'b0;
      cnt       <= '0;
      phase     <= 1'b0;
      tens_seen <= 1'b0;
      had_valid <= 1'b0;
      o_tens    <= '0;
      o_ones    <= '0;
      o_value   <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      seg_s1   <= i_seg;
      seg_s2   <= seg_s1;
      sel_s1   <= i_sel;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
      seg_prev <= seg_lit;
      o_valid  <= 1'b0;
      case (state)
        IDLE, WAIT: begin
          if (sel_edge) begin
            state <= SETTLE;
            cnt   <= '0;
            phase <= sel_s2;
          end
        end
        SETTLE: begin
          if (sel_edge) begin
            cnt   <= '0;
            phase <= sel_s2;
          end else if (seg_lit != seg_prev) begin
            cnt <= '0;
          end else if (cnt + 8'd1 == SETTLE_TC) begin
            cnt   <= cnt + 8'd1;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CAPTURE: begin
          if (!phase) begin
            o_tens    <= digit;
            tens_seen <= 1'b1;
            o_err     <= !digit_ok;
          end else begin
            o_ones <= digit;
            if (tens_seen) begin
              tens_seen <= 1'b0;
              o_err     <= !frame_ok;
              if (frame_ok) begin
                o_value   <= frame_value;
                had_valid <= 1'b1;
                o_valid   <= report;
              end
            end
          end
          // an edge landing on the capture cycle must not be lost
          if (sel_edge) begin
            state <= SETTLE;
            cnt   <= '0;
            phase <= sel_s2;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Bench for seg7_mux_decoder: phase-level reference model (digit lookup, frame arithmetic, fixed
// capture latency) compared against the DUT every cycle, plus literal checks of the key scenarios.
`timescale 1ns/1ps
module tb_seg7_mux_decoder;

  localparam int S = 16;
`ifdef SEG7_DECODE_CHANGE_ONLY_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_seg = 7'h7F;
  logic       i_sel = 1'b0;
  logic [3:0] o_tens, o_ones;
  logic [6:0] o_value;
  logic       o_valid, o_err;

  seg7_mux_decoder #(.SETTLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_seg(i_seg), .i_sel(i_sel),
    .o_tens(o_tens), .o_ones(o_ones), .o_value(o_value), .o_valid(o_valid), .o_err(o_err)
  );

  always #18.5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int vcount = 0, last_vcyc = 0;

  logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111};

  // model: m_* are the values after the current phase's capture, pre_* the values before it
  int m_tens = 0, m_ones = 0, m_value = 0, m_err = 0;
  int pre_tens = 0, pre_ones = 0, pre_value = 0, pre_err = 0;
  bit post_valid = 0, tens_seen = 0, last_sel = 0, had = 0;
  int upd_cyc = 0;

  function automatic int dec(input logic [6:0] lit);
    for (int i = 0; i < 10; i++) if (pat[i] == lit) return i;
    return 15;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // outputs switch from pre to post exactly S+4 cycles after the last input change
  always @(negedge i_clk) begin
    bit late;
    late = (cyc >= upd_cyc);
    check("o_tens",  int'(o_tens),  late ? m_tens  : pre_tens);
    check("o_ones",  int'(o_ones),  late ? m_ones  : pre_ones);
    check("o_value", int'(o_value), late ? m_value : pre_value);
    check("o_err",   int'(o_err),   late ? m_err   : pre_err);
    check("o_valid", int'(o_valid), int'((cyc == upd_cyc) && post_valid));
    if (o_valid) begin
      vcount++;
      last_vcyc = cyc;
    end
  end

  task automatic phase(input bit sel, input logic [6:0] lit, input int len, input int glitch);
    int d, nv;
    pre_tens = m_tens; pre_ones = m_ones; pre_value = m_value; pre_err = m_err;
    post_valid = 0;
    if (sel != last_sel) begin
      d = dec(lit);
      if (!sel) begin
        m_tens = d; tens_seen = 1; m_err = (d == 15);
      end else begin
        m_ones = d;
        if (tens_seen) begin
          tens_seen = 0;
          m_err = (m_tens == 15) || (d == 15);
          if (!m_err) begin
            nv = m_tens * 10 + d;
            post_valid = !CHG || !had || (nv != m_value);
            m_value = nv;
            had = 1;
          end
        end
      end
    end
    last_sel = sel;
    i_sel = sel;
    i_seg = ~lit;
    upd_cyc = cyc + S + 4;
    for (int k = 1; k < len; k++) begin
      @(posedge i_clk); #1;
      if (k < glitch && k % 10 == 0) begin
        i_seg = ~(lit ^ 7'h08);
        upd_cyc = cyc + S + 4;
      end else if (k > 10 && k % 10 == 1 && (k - 1) < glitch) begin
        i_seg = ~lit;
        upd_cyc = cyc + S + 4;
      end
    end
    @(posedge i_clk); #1;
  endtask

  task automatic frame(input int t, input int o, input int len);
    phase(1'b0, pat[t], len, 0);
    phase(1'b1, pat[o], len, 0);
  endtask

  task automatic do_reset(input int hold);
    i_rst = 1'b1;
    m_tens = 0; m_ones = 0; m_value = 0; m_err = 0;
    pre_tens = 0; pre_ones = 0; pre_value = 0; pre_err = 0;
    post_valid = 0; tens_seen = 0; last_sel = 0; had = 0;
    #1;
    check("rst_tens",  int'(o_tens), 0);
    check("rst_ones",  int'(o_ones), 0);
    check("rst_value", int'(o_value), 0);
    check("rst_err",   int'(o_err), 0);
    repeat (hold) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    int v0, start, sel_r, g, len;
    logic [6:0] lit;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("init_value", int'(o_value), 0);
    check("init_valid", int'(o_valid), 0);

    // ones phase with no tens seen: only o_ones moves
    phase(1'b1, pat[4], 30, 0);
    check("orphan_ones", int'(o_ones), 4);
    check("orphan_value", int'(o_value), 0);
    check("orphan_nopulse", vcount, 0);

    v0 = vcount;
    repeat (3) frame(5, 9, 40);
    check("f59_tens", int'(o_tens), 5);
    check("f59_ones", int'(o_ones), 9);
    check("f59_value", int'(o_value), 59);
    check("f59_pulses", vcount - v0, CHG ? 1 : 3);

    phase(1'b0, pat[1], 30, 0);
    start = cyc;
    phase(1'b1, pat[7], 30, 0);
    check("latency", last_vcyc - start, 20);

    for (int v = 59; v >= 0; v--) repeat (4) frame(v / 10, v % 10, 26);
    check("countdown_end", int'(o_value), 0);
    check("countdown_err", int'(o_err), 0);

    frame(4, 2, 30);
    check("pre_dash", int'(o_value), 42);
    v0 = vcount;
    phase(1'b0, 7'b1000000, 30, 0);
    check("dash_tens", int'(o_tens), 15);
    check("dash_err", int'(o_err), 1);
    phase(1'b1, pat[5], 30, 0);
    check("dash_hold", int'(o_value), 42);
    check("dash_nopulse", vcount - v0, 0);
    check("dash_err_frame", int'(o_err), 1);

    phase(1'b0, pat[3], 30, 0);
    v0 = vcount;
    start = cyc;
    phase(1'b1, pat[8], 90, 60);
    check("glitch_latency", last_vcyc - (start + 51), 20);
    check("glitch_pulses", vcount - v0, 1);
    check("glitch_value", int'(o_value), 38);

    phase(1'b0, pat[7], 30, 0);
    phase(1'b1, pat[3], 10, 0);
    do_reset(3);
    phase(1'b1, pat[3], 30, 0);
    check("post_rst_value", int'(o_value), 0);
    frame(7, 3, 30);
    check("f73_value", int'(o_value), 73);

    do_reset(2);
    phase(1'b1, pat[0], 30, 0);
    v0 = vcount;
    repeat (5) frame(1, 2, 30);
    check("rep12_pulses", vcount - v0, CHG ? 1 : 5);
    check("rep12_value", int'(o_value), 12);

    for (int n = 0; n < 200; n++) begin
      sel_r = ($urandom_range(0, 7) == 0) ? int'(i_sel) : int'(!i_sel);
      if ($urandom_range(0, 4) == 0) lit = 7'($urandom_range(0, 127));
      else lit = pat[$urandom_range(0, 9)];
      g = ($urandom_range(0, 5) == 0) ? 30 : 0;
      len = g + 26 + $urandom_range(0, 20);
      phase(sel_r[0], lit, len, g);
    end

    repeat (4) @(posedge i_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
